fetch_unit: RTL and testbench
=============================

# fetch_unit

Pipeline front end: owns the PC, issues instruction fetches to a variable-latency instruction memory, and presents each fetched instruction with its PC+2 to the IF_ID latch. It also honours back-pressure from the hazard unit, redirects from the memory stage's branch/jump resolution, and stops fetching after a HALT. It replaces the bare fetch stage in the pipelined top and feeds IF_ID directly.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset.
- NOP_INSTR, 16'h0800, instruction word driven on instr_out when no valid instruction is held.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- imem_req  out  1  fetch request; once asserted it is held until imem_ready is sampled high.
- imem_addr  out  16  fetch address, equal to the PC; bit 0 is always 0.
- imem_ready  in  1  memory response valid; imem_data is valid in the same cycle.
- imem_data  in  16  instruction word.
- stall  in  1  IF_ID cannot accept; the output registers hold while stall=1 and valid_out=1.
- redirect  in  1  taken branch or jump resolved downstream.
- redirect_pc  in  16  new PC; bit 0 is ignored and forced to 0.
- instr_out  out  16  instruction to IF_ID.
- pc_next_out  out  16  address of instr_out + 2, going to IF_ID.
- valid_out  out  1  instr_out and pc_next_out hold a real instruction.
- halted  out  1  a HALT has been delivered and fetching has stopped.

## Operation
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0 during the reset cycle, instr_out=NOP_INSTR, pc_next_out=0, valid_out=0, halted=0, buffer empty.
- Output free when valid_out=0 or stall=0.
- States:
  - FETCH: imem_req=1 when the output is free, else 0. Once imem_req=1, an edge with imem_ready=1 delivers the response (see Delivery). An edge with imem_ready=0 goes to WAIT.
  - WAIT: imem_req=1 and imem_addr=pc are held. On an edge with imem_ready=1:
    - If the output is free, deliver the response and go to FETCH.
    - If the output is not free, capture imem_data into the 1-entry buffer, set pc<=pc+2, and go to BUF.
  - BUF: imem_req=0. When stall=0, move the buffer into the output registers and go to FETCH.
  - DRAIN: imem_req=1 with the stale address held. On an edge with imem_ready=1, drop the data and go to FETCH using the redirected pc.
  - HALTED: imem_req=0 and halted=1. Only redirect or reset leaves this state.
- Delivery means: instr_out<=data, pc_next_out<=pc+2, valid_out<=1, pc<=pc+2.
  - If data[15:11]==5'b00000 (HALT), the state goes to HALTED after delivery instead of FETCH.
  - A HALT captured in BUF goes to HALTED when it is moved to the output.
- If the output is free and no new instruction is delivered on an edge, set valid_out<=0 and instr_out<=NOP_INSTR.
- redirect has the highest priority and ignores stall and state. On an edge with redirect=1:
  - pc<=redirect_pc&16'hFFFE.
  - valid_out<=0, instr_out<=NOP_INSTR.
  - The buffer is cleared and halted<=0.
  - Next state is DRAIN if a request is outstanding (imem_req=1) and imem_ready=0 on that edge; otherwise FETCH. A response arriving on the redirect edge is discarded.
- PC arithmetic is 16-bit modulo: pc=16'hFFFE advances to 16'h0000, and pc_next_out wraps the same way.
- While rst=0, all state returns to reset values on the next edge, whatever state it was in. An outstanding memory request is abandoned, and the memory is required to tolerate this.

## Timing
- Zero-wait memory (imem_ready high in the request cycle): the instruction appears on instr_out/valid_out one cycle after the request, and throughput is 1 instruction/cycle.
- N-wait memory: valid_out rises on the edge that samples imem_ready=1, so latency is N+1 cycles.
- imem_req, imem_addr, and the state update on the edge. The FETCH-state gating of imem_req on stall/valid_out is combinational.
- Redirect-to-first-valid: 1 edge plus the memory latency, plus the DRAIN cycles if a request was outstanding.
- With no redirect, every accepted fetch is delivered exactly once and in order. Nothing is lost or duplicated across stall or BUF.

## Test plan
- Reset with RESET_PC=0, then zero-wait memory returning 0x4000..0x4003 from addresses 0,2,4,6:
  - Required: imem_addr 0,2,4,6 on consecutive cycles.
  - Required: valid_out rises on the first request's ready edge (one cycle after the first request), then stays high.
  - Required: pc_next_out 2,4,6,8.
- Memory with 2 wait states: imem_req and imem_addr held stable for 3 cycles per fetch, and valid_out pulses once per 3 cycles.
- stall=1 for 4 cycles while a fetch is in WAIT:
  - Required: the response goes to BUF and imem_req=0.
  - Required: after stall falls, the buffered word appears next, with no duplicate and no skipped address.
- Redirect to 0x0100 while the request at 0x0010 is outstanding (2 wait states):
  - Required: DRAIN, and the stale data is not delivered.
  - Required: the next imem_addr is 0x0100, and valid_out=0 with instr_out=0x0800 until 0x0100 returns.
- HALT (0x0000) returned at 0x0008:
  - Required: it is delivered with pc_next_out=0x000A, then halted=1 and imem_req=0 indefinitely.
  - Required: a redirect to 0x0020 clears halted and resumes fetching at 0x0020.
- Redirect to 0xFFFE, then run free: imem_addr sequence 0xFFFE, 0x0000, 0x0002, with pc_next_out 0x0000 for the first. Asserting rst=0 mid-WAIT returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Pipeline front end: owns the PC, fetches from a variable-latency instruction
// memory and hands instructions plus PC+2 to the IF_ID latch.
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr_out,
    output logic [15:0] pc_next_out,
    output logic        valid_out,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT, S_BUF, S_DRAIN, S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcn_q, pcn_d;
    logic        valid_q, valid_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] buf_pcn_q, buf_pcn_d;
    logic [15:0] drain_addr_q, drain_addr_d;

    logic        out_free;
    logic        req_c;
    logic        take_mem;
    logic        moved;
    logic [15:0] pc_inc;
    logic [15:0] addr_c;

    always_comb begin
        out_free     = !valid_q || !stall;
        pc_inc       = pc_q + 16'd2;
        addr_c       = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
        req_c        = 1'b0;
        take_mem     = 1'b0;
        moved        = 1'b0;
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcn_d        = pcn_q;
        valid_d      = valid_q;
        buf_d        = buf_q;
        buf_pcn_d    = buf_pcn_q;
        drain_addr_d = drain_addr_q;

        case (state_q)
            S_FETCH: begin
                req_c = out_free;
                if (req_c) begin
                    if (imem_ready) take_mem = 1'b1;
                    else            state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                if (imem_ready) begin
                    if (out_free) begin
                        take_mem = 1'b1;
                    end else begin
                        buf_d     = imem_data;
                        buf_pcn_d = pc_inc;
                        pc_d      = pc_inc;
                        state_d   = S_BUF;
                    end
                end
            end
            S_BUF: begin
                if (!stall) begin
                    instr_d = buf_q;
                    pcn_d   = buf_pcn_q;
                    valid_d = 1'b1;
                    moved   = 1'b1;
                    state_d = (buf_q[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
                end
            end
            S_DRAIN: begin
                // Stale response is consumed and thrown away.
                req_c = 1'b1;
                if (imem_ready) state_d = S_FETCH;
            end
            S_HALTED: ;
            default: state_d = S_FETCH;
        endcase

        if (take_mem) begin
            instr_d = imem_data;
            pcn_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            moved   = 1'b1;
            state_d = (imem_data[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
        end

        if (out_free && !moved) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        // Redirect overrides everything; an in-flight request must be drained first.
        if (redirect) begin
            pc_d         = redirect_pc & 16'hFFFE;
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            buf_d        = 16'h0000;
            buf_pcn_d    = 16'h0000;
            drain_addr_d = addr_c;
            state_d      = (req_c && !imem_ready) ? S_DRAIN : S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC & 16'hFFFE;
            instr_q      <= NOP_INSTR;
            pcn_q        <= 16'h0000;
            valid_q      <= 1'b0;
            buf_q        <= 16'h0000;
            buf_pcn_q    <= 16'h0000;
            drain_addr_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcn_q        <= pcn_d;
            valid_q      <= valid_d;
            buf_q        <= buf_d;
            buf_pcn_q    <= buf_pcn_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign imem_req    = rst && req_c;
    assign imem_addr   = addr_c;
    assign instr_out   = instr_q;
    assign pc_next_out = pcn_q;
    assign valid_out   = valid_q;
    assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: startup vector table, directed corner sequences and a
// randomized run checked against an in-order fetch-stream model.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] instr_out;
    logic [15:0] pc_next_out;
    logic        valid_out;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: responds after a programmable number of wait cycles.
    int          fixed_waits = 0;
    int          rnd_waits   = 0;
    bit          rnd_mode    = 1'b0;
    int          wcnt        = 0;
    bit          halt_en     = 1'b0;
    logic [15:0] halt_addr   = 16'h0000;

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return 16'h4000 | (a >> 1);
    endfunction

    assign imem_ready = imem_req && (wcnt >= (rnd_mode ? rnd_waits : fixed_waits));
    assign imem_data  = (halt_en && imem_addr == halt_addr) ? 16'h0000 : data_of(imem_addr);

    always @(posedge clk) begin
        if (!rst) wcnt <= 0;
        else if (imem_req) begin
            if (imem_ready) begin
                wcnt <= 0;
                if (rnd_mode) rnd_waits <= $urandom_range(0, 3);
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_out(instr_out), .pc_next_out(pc_next_out),
        .valid_out(valid_out), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        nxt(); nxt();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] instr;
        logic [15:0] pcn;
    } vec_t;

    vec_t        tbl[9];
    logic [15:0] exp_addr;
    logic        pend;
    logic [15:0] pend_addr;
    int          n_dlv;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h4000, 16'h0002};
        tbl[2] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h4001, 16'h0004};
        tbl[3] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h4002, 16'h0006};
        tbl[4] = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h4003, 16'h0008};
        tbl[5] = '{1'b1, 1'b0, 16'h000A, 1'b1, 16'h4004, 16'h000A};
        tbl[6] = '{1'b1, 1'b0, 16'h000A, 1'b1, 16'h4004, 16'h000A};
        tbl[7] = '{1'b0, 1'b1, 16'h000A, 1'b1, 16'h4004, 16'h000A};
        tbl[8] = '{1'b0, 1'b1, 16'h000C, 1'b1, 16'h4005, 16'h000C};

        // Reset values, observed while rst is still held low.
        rst = 1'b0;
        nxt();
        @(negedge clk);
        chk("rst_req",    {15'd0, imem_req},  16'h0000);
        chk("rst_valid",  {15'd0, valid_out}, 16'h0000);
        chk("rst_instr",  instr_out,          16'h0800);
        chk("rst_pcn",    pc_next_out,        16'h0000);
        chk("rst_halted", {15'd0, halted},    16'h0000);
        chk("rst_addr",   imem_addr,          16'h0000);
        nxt();
        rst = 1'b1;

        // Zero-wait streaming, then a short stall.
        for (int i = 0; i < 9; i++) begin
            stall = tbl[i].stall;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i),   {15'd0, imem_req},  {15'd0, tbl[i].req});
            chk($sformatf("tbl%0d_addr", i),  imem_addr,          tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), {15'd0, valid_out}, {15'd0, tbl[i].vld});
            chk($sformatf("tbl%0d_instr", i), instr_out,          tbl[i].instr);
            chk($sformatf("tbl%0d_pcn", i),   pc_next_out,        tbl[i].pcn);
            nxt();
        end

        // Two wait states: address held 3 cycles, valid pulses once per 3.
        fixed_waits = 2;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("w2_req%0d", c),   {15'd0, imem_req},  16'h0001);
            chk($sformatf("w2_addr%0d", c),  imem_addr,          16'(2 * (c / 3)));
            chk($sformatf("w2_valid%0d", c), {15'd0, valid_out}, {15'd0, (c % 3 == 0) && (c > 0)});
            nxt();
        end

        // Stall for 4 cycles while a fetch waits on memory.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            stall = (c >= 1 && c <= 4);
            @(negedge clk);
            if (c == 3 || c == 4) begin
                chk($sformatf("st_req%0d", c),   {15'd0, imem_req},  16'h0000);
                chk($sformatf("st_hold%0d", c),  instr_out,          16'h4000);
                chk($sformatf("st_valid%0d", c), {15'd0, valid_out}, 16'h0001);
            end
            if (c == 5) begin
                chk("st_resume_addr", imem_addr, 16'h0002);
                chk("st_resume_req",  {15'd0, imem_req}, 16'h0001);
            end
            if (c == 6) chk("st_no_dup", {15'd0, valid_out}, 16'h0000);
            if (c == 8) begin
                chk("st_next_instr", instr_out,   16'h4001);
                chk("st_next_pcn",   pc_next_out, 16'h0004);
            end
            nxt();
        end

        // Redirect while a 2-wait request is outstanding.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            redirect    = (c == 0 || c == 4);
            redirect_pc = (c == 0) ? 16'h0010 : 16'h0100;
            @(negedge clk);
            if (c == 4) chk("rd_addr_pre", imem_addr, 16'h0010);
            if (c == 5) begin
                chk("rd_drain_addr", imem_addr, 16'h0010);
                chk("rd_drain_req",  {15'd0, imem_req}, 16'h0001);
            end
            if (c >= 5 && c <= 8) begin
                chk($sformatf("rd_valid%0d", c), {15'd0, valid_out}, 16'h0000);
                chk($sformatf("rd_instr%0d", c), instr_out, 16'h0800);
            end
            if (c == 6) chk("rd_new_addr", imem_addr, 16'h0100);
            if (c == 9) begin
                chk("rd_first_instr", instr_out,   16'h4080);
                chk("rd_first_pcn",   pc_next_out, 16'h0102);
                chk("rd_first_valid", {15'd0, valid_out}, 16'h0001);
            end
            nxt();
        end
        redirect = 1'b0;

        // HALT at 0x0008, then redirect out of it.
        fixed_waits = 0;
        halt_en     = 1'b1;
        halt_addr   = 16'h0008;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            redirect    = (c == 9);
            redirect_pc = 16'h0020;
            @(negedge clk);
            if (c == 4) chk("h_addr", imem_addr, 16'h0008);
            if (c == 5) begin
                chk("h_instr",  instr_out,          16'h0000);
                chk("h_pcn",    pc_next_out,        16'h000A);
                chk("h_valid",  {15'd0, valid_out}, 16'h0001);
            end
            if (c >= 5 && c <= 9) begin
                chk($sformatf("h_halted%0d", c), {15'd0, halted},   16'h0001);
                chk($sformatf("h_req%0d", c),    {15'd0, imem_req}, 16'h0000);
            end
            if (c == 10) begin
                chk("h_clear",   {15'd0, halted},   16'h0000);
                chk("h_res_req", {15'd0, imem_req}, 16'h0001);
                chk("h_res_addr", imem_addr,        16'h0020);
            end
            if (c == 11) begin
                chk("h_res_instr", instr_out,   16'h4010);
                chk("h_res_pcn",   pc_next_out, 16'h0022);
            end
            nxt();
        end
        redirect = 1'b0;
        halt_en  = 1'b0;

        // Redirect to the top of memory (odd target) and wrap.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            redirect    = (c == 0);
            redirect_pc = 16'hFFFF;
            @(negedge clk);
            if (c == 1) chk("wr_addr0", imem_addr, 16'hFFFE);
            if (c == 2) begin
                chk("wr_addr1", imem_addr,   16'h0000);
                chk("wr_instr", instr_out,   16'h7FFF);
                chk("wr_pcn0",  pc_next_out, 16'h0000);
            end
            if (c == 3) begin
                chk("wr_addr2", imem_addr,   16'h0002);
                chk("wr_pcn1",  pc_next_out, 16'h0002);
            end
            nxt();
        end
        redirect = 1'b0;

        // Reset asserted in the middle of a wait.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c == 3) fixed_waits = 3;
            if (c == 4) rst = 1'b0;
            @(negedge clk);
            if (c == 4) begin
                chk("mr_wait_valid", {15'd0, valid_out}, 16'h0000);
                chk("mr_req_gated",  {15'd0, imem_req},  16'h0000);
            end
            if (c == 5) begin
                chk("mr_valid",  {15'd0, valid_out}, 16'h0000);
                chk("mr_instr",  instr_out,          16'h0800);
                chk("mr_pcn",    pc_next_out,        16'h0000);
                chk("mr_addr",   imem_addr,          16'h0000);
                chk("mr_halted", {15'd0, halted},    16'h0000);
            end
            nxt();
        end

        // Randomized run: accepted instructions must follow the PC stream exactly.
        rnd_mode  = 1'b1;
        do_reset();
        exp_addr  = 16'h0000;
        pend      = 1'b0;
        pend_addr = 16'h0000;
        n_dlv     = 0;
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 3);
            redirect_pc = 16'($urandom);
            @(negedge clk);
            chk("rnd_addr_even", {15'd0, imem_addr[0]}, 16'h0000);
            if (pend) begin
                chk("rnd_req_hold",  {15'd0, imem_req}, 16'h0001);
                chk("rnd_addr_hold", imem_addr,         pend_addr);
            end
            if (redirect) begin
                exp_addr = redirect_pc & 16'hFFFE;
            end else if (valid_out && !stall) begin
                chk("rnd_instr", instr_out,   data_of(exp_addr));
                chk("rnd_pcn",   pc_next_out, exp_addr + 16'd2);
                exp_addr = exp_addr + 16'd2;
                n_dlv++;
            end
            pend      = imem_req && !imem_ready;
            pend_addr = imem_addr;
            nxt();
        end
        chk("rnd_progress", {15'd0, n_dlv > 300}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
